reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/rr_arbiter4.sv | 30 +++
 rtl/reg_write_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the four-requester register write arbiter.
package reg_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin picker: search starts one past the last winner
// and wraps, so the last winner has the lowest priority.
module rr_arbiter4
    import reg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_winner,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = i_last_winner;
        w_found = 1'b0;
        w_cand  = i_last_winner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = i_last_winner + IDX_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates four requesters onto one shared N-bit register write port, with
// an optional bounded lock that lets one requester keep ownership across beats.
//
//   state     | meaning
//   ST_IDLE   | round-robin arbitration among all valid requesters
//   ST_LOCKED | only r_owner may transfer; r_lock_cnt bounds the hold time
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 wr_en,
    output logic [N-1:0]         wr_data,
    output logic [IDX_W-1:0]     wr_owner,
    output logic                 busy,
    output logic                 lock_timeout
);

    localparam int            CW         = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_winner;
    logic [CW-1:0]      r_lock_cnt;
    logic               r_wr_en;
    logic [N-1:0]       r_wr_data;
    logic [IDX_W-1:0]   r_wr_owner;
    logic               r_lock_timeout;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_xfer;
    logic               w_sel_lock;
    logic [N-1:0]       w_sel_data;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_cnt_hit;
    logic               w_release;
    logic               w_timeout;

    rr_arbiter4 u_rr (
        .i_req         (req_valid),
        .i_last_winner (r_last_winner),
        .o_gnt         (w_arb_gnt),
        .o_idx         (w_arb_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer && w_sel_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_release || w_cnt_hit) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready   = '0;
        w_sel_idx = w_arb_idx;
        case (r_state)
            ST_IDLE: w_ready = w_arb_gnt;
            ST_LOCKED: begin
                w_sel_idx = r_owner;
                if (req_valid[r_owner]) w_ready = idx_to_onehot(r_owner);
            end
            default: w_ready = '0;
        endcase
    end

    assign w_xfer     = |w_ready;
    assign w_sel_lock = req_lock[w_sel_idx];
    assign w_sel_data = req_data[int'(w_sel_idx)*N +: N];
    assign w_cnt_inc  = r_lock_cnt + CW'(1);
    assign w_cnt_hit  = (w_cnt_inc == C_CNT_LAST);

    // In LOCKED a valid owner always transfers, so dropping lock releases
    // whether or not a final beat is presented.
    assign w_release  = !req_lock[r_owner];
    assign w_timeout  = (r_state == ST_LOCKED) && w_cnt_hit && !w_release;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner        <= '0;
            r_last_winner  <= IDX_W'(NUM_REQ - 1);
            r_lock_cnt     <= '0;
            r_wr_en        <= 1'b0;
            r_wr_data      <= '0;
            r_wr_owner     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_wr_en        <= w_xfer;
            r_lock_timeout <= w_timeout;
            if (w_xfer) begin
                r_wr_data     <= w_sel_data;
                r_wr_owner    <= w_sel_idx;
                r_last_winner <= w_sel_idx;
            end
            if (w_timeout) r_last_winner <= r_owner;
            if (r_state == ST_IDLE) begin
                r_lock_cnt <= '0;
                if (w_xfer && w_sel_lock) r_owner <= w_sel_idx;
            end else begin
                r_lock_cnt <= w_cnt_inc;
            end
        end
    end

    assign req_ready    = reset_n ? w_ready : '0;
    assign wr_en        = r_wr_en;
    assign wr_data      = r_wr_data;
    assign wr_owner     = r_wr_owner;
    assign busy         = (r_state == ST_LOCKED);
    assign lock_timeout = r_lock_timeout;

endmodule
